// File: rtl/key_debounce_array.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// key_debounce_array
//
// Debounces NUM_KEYS independent push buttons against one shared millisecond
// tick. Each channel reports accepted press/release pulses, a stable hold
// level, a single long-press pulse and periodic auto-repeat pulses after it.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   key_in       raw asynchronous key pins (polarity set by ACTIVE_LOW)
//   key_press    1-cycle pulse when a press is accepted
//   key_release  1-cycle pulse when a release is accepted
//   key_hold     high from accepted press until accepted release
//   key_long     1-cycle pulse once per press after LONG_MS of holding
//   key_repeat   1-cycle pulse every REPEAT_MS after key_long (0 = off)
//   key_any      OR of all key_hold bits
// ---------------------------------------------------------------------------
module key_debounce_array #(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_hold,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                key_any
);

  // Clamped at 1 so a very slow clock still produces a tick every cycle.
  localparam int TICK_DIV = (CLK_FREQ / 1000 >= 1) ? (CLK_FREQ / 1000) : 1;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_DL   = (DEBOUNCE_MS > LONG_MS) ? DEBOUNCE_MS : LONG_MS;
  localparam int MAX_MS   = (MAX_DL > REPEAT_MS) ? MAX_DL : REPEAT_MS;
  localparam int CW       = $clog2(MAX_MS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_MS - 1);
  // Long-press time counts from the first stable level, so the debounce
  // time already spent before acceptance is taken off here.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_MS > 0) ? (REPEAT_MS - 1) : 0);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic          IDLE_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRE_DOWN = 2'd1,
    DOWN     = 2'd2,
    PRE_UP   = 2'd3
  } keyState_e;

  logic [NUM_KEYS-1:0] sync0_q, sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] act;
  logic [TW-1:0]       tickCnt_q;
  logic                tick;

  keyState_e           state_q [NUM_KEYS];
  keyState_e           state_d [NUM_KEYS];
  logic [CW-1:0]       dcnt_q  [NUM_KEYS];
  logic [CW-1:0]       dcnt_d  [NUM_KEYS];
  logic [CW-1:0]       hcnt_q  [NUM_KEYS];
  logic [CW-1:0]       hcnt_d  [NUM_KEYS];
  logic [NUM_KEYS-1:0] longFlag_q, longFlag_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] hold_q, hold_d;
  logic [NUM_KEYS-1:0] long_q, long_d;
  logic [NUM_KEYS-1:0] repeat_q, repeat_d;

  // Three-flop synchroniser per pin. Reset loads the released level so no
  // phantom press appears while the chain refills after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0_q <= {NUM_KEYS{IDLE_LVL}};
      sync1_q <= {NUM_KEYS{IDLE_LVL}};
      sync2_q <= {NUM_KEYS{IDLE_LVL}};
    end else begin
      sync0_q <= key_in;
      sync1_q <= sync0_q;
      sync2_q <= sync1_q;
    end
  end

  // act is 1 whenever a key is pressed, whatever the pin polarity.
  assign act = sync2_q ^ {NUM_KEYS{IDLE_LVL}};

  // Shared millisecond prescaler: tick is high during the last count.
  assign tick = (tickCnt_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tickCnt_q <= '0;
    end else if (tick) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_q + TW'(1);
    end
  end

  // Per-key next-state logic. A change of act always takes priority over a
  // coinciding tick, so a bounce restarts acceptance without counting.
  // While waiting for release confirmation the hold counter is frozen.
  always_comb begin
    press_d    = '0;
    release_d  = '0;
    long_d     = '0;
    repeat_d   = '0;
    hold_d     = hold_q;
    longFlag_d = longFlag_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      state_d[k] = state_q[k];
      dcnt_d[k]  = dcnt_q[k];
      hcnt_d[k]  = hcnt_q[k];
      case (state_q[k])
        IDLE: begin
          if (act[k]) begin
            state_d[k] = PRE_DOWN;
            dcnt_d[k]  = '0;
          end
        end
        PRE_DOWN: begin
          if (!act[k]) begin
            state_d[k] = IDLE;
          end else if (tick) begin
            if (dcnt_q[k] == DEB_LAST) begin
              state_d[k]    = DOWN;
              press_d[k]    = 1'b1;
              hold_d[k]     = 1'b1;
              hcnt_d[k]     = '0;
              longFlag_d[k] = 1'b0;
            end else begin
              dcnt_d[k] = dcnt_q[k] + CW'(1);
            end
          end
        end
        DOWN: begin
          if (!act[k]) begin
            state_d[k] = PRE_UP;
            dcnt_d[k]  = '0;
          end else if (tick) begin
            if (!longFlag_q[k]) begin
              if (hcnt_q[k] == LONG_LAST) begin
                long_d[k]     = 1'b1;
                longFlag_d[k] = 1'b1;
                hcnt_d[k]     = '0;
              end else begin
                hcnt_d[k] = hcnt_q[k] + CW'(1);
              end
            end else if (REPEAT_MS > 0) begin
              if (hcnt_q[k] == REP_LAST) begin
                repeat_d[k] = 1'b1;
                hcnt_d[k]   = '0;
              end else begin
                hcnt_d[k] = hcnt_q[k] + CW'(1);
              end
            end else if (hcnt_q[k] != CNT_MAX) begin
              hcnt_d[k] = hcnt_q[k] + CW'(1);
            end
          end
        end
        PRE_UP: begin
          if (act[k]) begin
            state_d[k] = DOWN;
          end else if (tick) begin
            if (dcnt_q[k] == DEB_LAST) begin
              state_d[k]   = IDLE;
              release_d[k] = 1'b1;
              hold_d[k]    = 1'b0;
            end else begin
              dcnt_d[k] = dcnt_q[k] + CW'(1);
            end
          end
        end
        default: begin
          state_d[k] = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs. Reset drops hold immediately
  // and suppresses every pulse, including the release of a held key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= IDLE;
        dcnt_q[k]  <= '0;
        hcnt_q[k]  <= '0;
      end
      longFlag_q <= '0;
      press_q    <= '0;
      release_q  <= '0;
      hold_q     <= '0;
      long_q     <= '0;
      repeat_q   <= '0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      hcnt_q     <= hcnt_d;
      longFlag_q <= longFlag_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_q     <= hold_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_hold    = hold_q;
  assign key_long    = long_q;
  assign key_repeat  = repeat_q;
  assign key_any     = |hold_q;

endmodule

// File: tb/tb_key_debounce_array.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_key_debounce_array
//
// Directed table of input segments with hand-derived pulse counts, a
// hand-written reset-to-press latency sequence, and randomized segments.
// A behavioural reference model, built from stable-time arithmetic on the
// delayed pin level, predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_key_debounce_array;

  localparam int NK         = 2;
  localparam int CLK_FREQ   = 10_000;
  localparam int DEB        = 3;
  localparam int LONG       = 10;
  localparam int REP        = 4;
  localparam int ACTIVE_LOW = 1;
  localparam int TICK_DIV   = CLK_FREQ / 1000;
  localparam bit PRESS_LVL  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam bit IDLE_LVL   = ~PRESS_LVL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_press, key_release, key_hold, key_long, key_repeat;
  logic          key_any;

  key_debounce_array #(
    .NUM_KEYS(NK), .CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEB),
    .LONG_MS(LONG), .REPEAT_MS(REP), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_press(key_press), .key_release(key_release), .key_hold(key_hold),
    .key_long(key_long), .key_repeat(key_repeat), .key_any(key_any)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model state: pin history, whether the key is considered held,
  // ticks seen since the pressed level last changed, and ticks accumulated
  // while held with a stable pressed level.
  bit [2:0]      mHist [NK];
  bit            mHeld [NK];
  bit            mPrev [NK];
  int            mRun [NK];
  int            mHoldTicks [NK];
  int            mCyc;
  bit            mValid = 1'b0;
  logic [NK-1:0] ePress, eRel, eHold, eLong, eRep;

  // Model update on every active edge. Press is accepted once the pressed
  // level has been stable for DEB ticks, release likewise; long fires at
  // LONG-DEB held ticks, repeats every REP held ticks beyond that.
  always @(posedge clk) begin : refModel
    bit tickNow, a, stable;
    if (!rst_n) begin
      mCyc   = 0;
      mValid = 1'b1;
      ePress = '0; eRel = '0; eHold = '0; eLong = '0; eRep = '0;
      for (int k = 0; k < NK; k++) begin
        mHist[k]      = {3{IDLE_LVL}};
        mHeld[k]      = 1'b0;
        mPrev[k]      = 1'b0;
        mRun[k]       = 0;
        mHoldTicks[k] = 0;
      end
    end else begin
      tickNow = ((mCyc % TICK_DIV) == (TICK_DIV - 1));
      mCyc++;
      ePress = '0; eRel = '0; eLong = '0; eRep = '0;
      for (int k = 0; k < NK; k++) begin
        a      = (mHist[k][2] == PRESS_LVL);
        stable = (a == mPrev[k]);
        if (!stable) mRun[k] = 0;
        else if (tickNow) mRun[k]++;
        if (mHeld[k] && a && stable && tickNow) begin
          mHoldTicks[k]++;
          if (mHoldTicks[k] == LONG - DEB) eLong[k] = 1'b1;
          else if (REP > 0 && mHoldTicks[k] > LONG - DEB &&
                   ((mHoldTicks[k] - (LONG - DEB)) % REP) == 0) eRep[k] = 1'b1;
        end
        if (!mHeld[k] && a && mRun[k] == DEB) begin
          ePress[k]     = 1'b1;
          mHeld[k]      = 1'b1;
          mHoldTicks[k] = 0;
        end else if (mHeld[k] && !a && mRun[k] == DEB) begin
          eRel[k]  = 1'b1;
          mHeld[k] = 1'b0;
        end
        mPrev[k] = a;
        mHist[k] = {mHist[k][1:0], key_in[k]};
      end
      for (int k = 0; k < NK; k++) eHold[k] = mHeld[k];
    end
  end

  typedef struct {
    logic          rstN;
    logic [NK-1:0] keyIn;
    int            cycles;
    int            press0, rel0, long0, rep0, press1, rel1;
    logic [NK-1:0] holdEnd;
  } vec_t;

  vec_t vecs[$];
  int   cntPress [NK];
  int   cntRel [NK];
  int   cntLong [NK];
  int   cntRep [NK];
  int   seen, waited, rndLen, rstLen;
  logic [NK-1:0] rndKeys;

  function automatic void addVec(input logic r, input logic [NK-1:0] k, input int c,
                                 input int p0, input int r0, input int l0, input int rp0,
                                 input int p1, input int r1, input logic [NK-1:0] h);
    vec_t v;
    v.rstN = r; v.keyIn = k; v.cycles = c;
    v.press0 = p0; v.rel0 = r0; v.long0 = l0; v.rep0 = rp0;
    v.press1 = p1; v.rel1 = r1; v.holdEnd = h;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // One clock cycle: outputs are sampled on the falling edge, compared with
  // the model and accumulated into the per-segment pulse counters.
  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    if (mValid) begin
      checkOutput("cycle_outputs",
                  32'({key_press, key_release, key_hold, key_long, key_repeat, key_any}),
                  32'({ePress, eRel, eHold, eLong, eRep, |eHold}));
    end
    for (int k = 0; k < NK; k++) begin
      cntPress[k] += int'(key_press[k]);
      cntRel[k]   += int'(key_release[k]);
      cntLong[k]  += int'(key_long[k]);
      cntRep[k]   += int'(key_repeat[k]);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    rst_n  = v.rstN;
    key_in = v.keyIn;
    for (int k = 0; k < NK; k++) begin
      cntPress[k] = 0; cntRel[k] = 0; cntLong[k] = 0; cntRep[k] = 0;
    end
    repeat (v.cycles) stepCycle();
    checkOutput($sformatf("row%0d_press0", idx),  cntPress[0], v.press0);
    checkOutput($sformatf("row%0d_release0", idx), cntRel[0], v.rel0);
    checkOutput($sformatf("row%0d_long0", idx),   cntLong[0], v.long0);
    checkOutput($sformatf("row%0d_repeat0", idx), cntRep[0], v.rep0);
    checkOutput($sformatf("row%0d_press1", idx),  cntPress[1], v.press1);
    checkOutput($sformatf("row%0d_release1", idx), cntRel[1], v.rel1);
    checkOutput($sformatf("row%0d_long1", idx),   cntLong[1], 0);
    checkOutput($sformatf("row%0d_hold_end", idx), 32'(key_hold), 32'(v.holdEnd));
    checkOutput($sformatf("row%0d_any_end", idx),  32'(key_any), 32'(|v.holdEnd));
  endtask

  initial begin
    // Reset with both pins pressed, then both accepted and released.
    addVec(1'b0, 2'b00, 5,  0, 0, 0, 0, 0, 0, 2'b00);
    addVec(1'b1, 2'b00, 40, 1, 0, 0, 0, 1, 0, 2'b11);
    addVec(1'b1, 2'b11, 40, 0, 1, 0, 0, 0, 1, 2'b00);
    // Clean press and release of key0.
    addVec(1'b1, 2'b10, 80, 1, 0, 0, 0, 0, 0, 2'b01);
    addVec(1'b1, 2'b11, 40, 0, 1, 0, 0, 0, 0, 2'b00);
    // Bouncing pin toggling every 15 cycles never gets accepted.
    for (int i = 0; i < 14; i++)
      addVec(1'b1, (i % 2 == 0) ? 2'b10 : 2'b11, 15, 0, 0, 0, 0, 0, 0, 2'b00);
    addVec(1'b1, 2'b11, 40, 0, 0, 0, 0, 0, 0, 2'b00);
    // Long press with three repeats, then release.
    addVec(1'b1, 2'b10, 220, 1, 0, 1, 3, 0, 0, 2'b01);
    addVec(1'b1, 2'b11, 40,  0, 1, 0, 0, 0, 0, 2'b00);
    // Short release glitch while held: no release, long delayed one tick.
    addVec(1'b1, 2'b10, 60,  1, 0, 0, 0, 0, 0, 2'b01);
    addVec(1'b1, 2'b11, 15,  0, 0, 0, 0, 0, 0, 2'b01);
    addVec(1'b1, 2'b10, 100, 0, 0, 1, 1, 0, 0, 2'b01);
    addVec(1'b1, 2'b11, 40,  0, 1, 0, 0, 0, 0, 2'b00);
    // Two keys pressed five cycles apart, then reset mid-press.
    addVec(1'b1, 2'b10, 5,  0, 0, 0, 0, 0, 0, 2'b00);
    addVec(1'b1, 2'b00, 40, 1, 0, 0, 0, 1, 0, 2'b11);
    addVec(1'b0, 2'b00, 5,  0, 0, 0, 0, 0, 0, 2'b00);
    addVec(1'b1, 2'b11, 40, 0, 0, 0, 0, 0, 0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Reset-to-press latency: sync fill, then three ticks at cycles 10/20/30.
    rst_n  = 1'b0;
    key_in = 2'b00;
    repeat (5) stepCycle();
    checkOutput("reset_outputs_zero",
                32'({key_press, key_release, key_hold, key_long, key_repeat, key_any}), 32'd0);
    rst_n  = 1'b1;
    seen   = 0;
    waited = 0;
    while (seen == 0 && waited < 40) begin
      stepCycle();
      waited++;
      if (key_press[0]) seen = 1;
    end
    checkOutput("reset_to_press_seen", seen, 1);
    checkOutput("reset_to_press_cycles", waited, 30);
    checkOutput("press_hold_together", 32'(key_hold[0]), 32'd1);
    key_in = 2'b11;
    repeat (40) stepCycle();

    // Randomized segments, including short bounces, long holds and resets.
    for (int s = 0; s < 120; s++) begin
      rndKeys = NK'($urandom);
      case ($urandom_range(0, 3))
        0:       rndLen = $urandom_range(1, 12);
        1:       rndLen = $urandom_range(13, 40);
        2:       rndLen = $urandom_range(41, 250);
        default: rndLen = $urandom_range(20, 60);
      endcase
      key_in = rndKeys;
      if ($urandom_range(0, 29) == 0) begin
        rstLen = $urandom_range(1, 3);
        rst_n  = 1'b0;
        repeat (rstLen) stepCycle();
        rst_n  = 1'b1;
      end
      repeat (rndLen) stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
